// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word fetches under a two-credit limit,
// buffers up to two returned instructions for decode, and discards the
// in-flight responses that a redirect has made stale.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
);

  typedef enum logic {
    S_FETCH,
    S_FLUSH
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;

  // Instruction buffer: entry 0 is the head presented to decode.
  logic        b0_vld;
  logic [31:0] b0_ins;
  logic [31:0] b0_pc;
  logic        b1_vld;
  logic [31:0] b1_ins;
  logic [31:0] b1_pc;

  // In-flight pc FIFO: entry 0 is the oldest outstanding request.
  logic [31:0] f0_pc;
  logic [31:0] f1_pc;
  logic [1:0]  inf_count;

  logic [1:0]  stale_count;
  logic [1:0]  stale_next;

  logic [2:0]  occupancy;
  logic        issue;
  logic        accept_rsp;
  logic        pop;
  logic        rsp_consume;

  assign occupancy   = {2'b00, b0_vld} + {2'b00, b1_vld} + {1'b0, inf_count};
  // Gated by reset_n so no request is presented while held in reset.
  assign imem_req    = reset_n && (state == S_FETCH) && !redirect && (occupancy < 3'd2);
  assign issue       = imem_req && imem_gnt;
  assign accept_rsp  = imem_rvalid && (state == S_FETCH) && !redirect;
  assign pop         = b0_vld && id_ready && !redirect;
  assign rsp_consume = imem_rvalid && (inf_count != 2'd0);

  assign imem_addr      = pc;
  assign if_valid       = b0_vld;
  assign if_instruction = b0_ins;
  assign if_pc          = b0_pc;

  // Next-state and stale-count update; a redirect turns every request
  // still outstanding after this cycle into a stale one.
  always_comb begin
    state_next = state;
    stale_next = stale_count;
    case (state)
      S_FETCH: begin
        if (redirect) begin
          stale_next = inf_count - {1'b0, rsp_consume};
          if (stale_next != 2'd0) state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (imem_rvalid && (stale_count != 2'd0)) stale_next = stale_count - 2'd1;
        if (stale_next == 2'd0) state_next = S_FETCH;
      end
      default: begin
        state_next = S_FETCH;
        stale_next = '0;
      end
    endcase
  end

  // FSM state and stale counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_FETCH;
      stale_count <= '0;
    end else begin
      state       <= state_next;
      stale_count <= stale_next;
    end
  end

  // Fetch PC: redirect wins over the increment on a granted request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (issue) begin
      pc <= pc + 32'd1;
    end
  end

  // In-flight FIFO: push issued address, pop on an accepted response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      f0_pc     <= '0;
      f1_pc     <= '0;
      inf_count <= '0;
    end else if (redirect) begin
      inf_count <= '0;
    end else begin
      case ({issue, accept_rsp})
        2'b10: begin
          if (inf_count == 2'd0) f0_pc <= pc;
          else                   f1_pc <= pc;
          inf_count <= inf_count + 2'd1;
        end
        2'b01: begin
          f0_pc <= f1_pc;
          if (inf_count != 2'd0) inf_count <= inf_count - 2'd1;
        end
        2'b11: begin
          if (inf_count == 2'd2) begin
            f0_pc <= f1_pc;
            f1_pc <= pc;
          end else begin
            f0_pc <= pc;
          end
        end
        default: ;
      endcase
    end
  end

  // Instruction buffer: push at the tail, pop from the head, shift on pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      b0_vld <= 1'b0;
      b0_ins <= '0;
      b0_pc  <= '0;
      b1_vld <= 1'b0;
      b1_ins <= '0;
      b1_pc  <= '0;
    end else if (redirect) begin
      b0_vld <= 1'b0;
      b1_vld <= 1'b0;
    end else begin
      case ({accept_rsp, pop})
        2'b10: begin
          if (!b0_vld) begin
            b0_vld <= 1'b1;
            b0_ins <= imem_rdata;
            b0_pc  <= f0_pc;
          end else begin
            b1_vld <= 1'b1;
            b1_ins <= imem_rdata;
            b1_pc  <= f0_pc;
          end
        end
        2'b01: begin
          b0_vld <= b1_vld;
          b0_ins <= b1_ins;
          b0_pc  <= b1_pc;
          b1_vld <= 1'b0;
        end
        2'b11: begin
          // Simultaneous push and pop: the new entry lands behind whatever
          // remains so ordering is preserved and the count is unchanged.
          if (b1_vld) begin
            b0_ins <= b1_ins;
            b0_pc  <= b1_pc;
            b1_ins <= imem_rdata;
            b1_pc  <= f0_pc;
          end else begin
            b0_ins <= imem_rdata;
            b0_pc  <= f0_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a queue-based instruction memory and an
// expected-stream model for the pcs decode must see, driven by directed
// scenarios followed by a randomized phase.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFF;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } mem_t;

  mem_t        mem_q[$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] exp_pc;
  logic [31:0] exp_issue;
  bit          prev_hold;
  bit          prev_redir;
  logic [31:0] prev_pc;
  logic [31:0] prev_ins;
  logic        s_v;
  logic        s_req;
  logic [31:0] s_pc;
  logic [31:0] s_ins;
  logic [31:0] s_addr;
  int unsigned n_iss;
  int unsigned n_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    exp_pc     = RST_PC;
    exp_issue  = RST_PC;
    prev_hold  = 0;
    prev_redir = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, sample 1ns later,
  // check against the model, then advance the model to the next edge.
  task automatic step(input bit g, input bit r, input bit rd, input logic [31:0] rpc,
                      input int unsigned lat);
    int unsigned nstale;
    int unsigned due;
    @(negedge clock);
    imem_gnt    = g;
    id_ready    = r;
    redirect    = rd;
    redirect_pc = rpc;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].addr ^ KEY;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    s_v = if_valid; s_req = imem_req; s_pc = if_pc; s_ins = if_instruction; s_addr = imem_addr;

    if (prev_hold) begin
      chk("hold_valid", {31'd0, s_v}, 32'd1);
      chk("hold_pc", s_pc, prev_pc);
      chk("hold_ins", s_ins, prev_ins);
    end
    if (prev_redir) chk("valid_after_redirect", {31'd0, s_v}, 32'd0);
    if (rd) chk("req_during_redirect", {31'd0, s_req}, 32'd0);

    nstale = 0;
    foreach (mem_q[i]) if (mem_q[i].stale) nstale++;
    if (nstale > 0) chk("req_in_flush", {31'd0, s_req}, 32'd0);

    if (s_v && r && !rd) begin
      chk("accept_pc", s_pc, exp_pc);
      chk("accept_ins", s_ins, exp_pc ^ KEY);
      exp_pc = exp_pc + 32'd1;
      n_acc++;
    end
    if (s_req && g) begin
      chk("issue_addr", s_addr, exp_issue);
      exp_issue = exp_issue + 32'd1;
      n_iss++;
    end

    if (imem_rvalid) void'(mem_q.pop_front());
    if (rd) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      exp_pc    = rpc;
      exp_issue = rpc;
    end
    if (s_req && g) begin
      due = cyc + ((lat == 0) ? 1 : lat);
      if (mem_q.size() > 0 && mem_q[mem_q.size()-1].due > due) due = mem_q[mem_q.size()-1].due;
      mem_q.push_back('{addr: s_addr, due: due, stale: 1'b0});
    end
    chk("outstanding_le2", {31'd0, mem_q.size() <= 2}, 32'd1);

    prev_hold  = s_v && !r && !rd;
    prev_pc    = s_pc;
    prev_ins   = s_ins;
    prev_redir = rd;
    cyc++;
  endtask

  task automatic wait_first_valid(input string tag, input logic [31:0] expv, input int unsigned budget);
    bit found;
    found = 0;
    for (int unsigned i = 0; i < budget; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0, 1);
      if (s_v) begin
        found = 1;
        break;
      end
    end
    chk({tag, "_found"}, {31'd0, found}, 32'd1);
    if (found) chk({tag, "_pc"}, s_pc, expv);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int unsigned i = 0; i < 30; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0, 1);
      if (mem_q.size() == 0 && !s_v) begin
        done = 1;
        break;
      end
    end
    chk("drain_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_errors = 0; n_iss = 0; n_acc = 0;
    reset_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    model_reset();

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_ins", if_instruction, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    reset_n = 1'b1;

    // First cycle out of reset, then backpressure for five cycles
    n_iss = 0;
    step(1'b1, 1'b0, 1'b0, 32'd0, 1);
    chk("first_req", {31'd0, s_req}, 32'd1);
    chk("first_addr", s_addr, RST_PC);
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0, 1);
    chk("bp_issues_le2", {31'd0, n_iss <= 2}, 32'd1);
    chk("bp_head_valid", {31'd0, s_v}, 32'd1);
    chk("bp_head_pc", s_pc, RST_PC);

    // Streaming with wrap from 0xFFFFFFFF to 0
    n_acc = 0;
    repeat (30) step(1'b1, 1'b1, 1'b0, 32'd0, 1);
    chk("stream_progress", {31'd0, n_acc >= 15}, 32'd1);
    drain();

    // Redirect with two requests in flight
    step(1'b1, 1'b1, 1'b0, 32'd0, 6);
    step(1'b1, 1'b1, 1'b0, 32'd0, 6);
    chk("two_in_flight", mem_q.size(), 32'd2);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1);
    wait_first_valid("redirect_100", 32'h0000_0100, 40);
    drain();

    // Double redirect while flushing
    step(1'b1, 1'b1, 1'b0, 32'd0, 6);
    step(1'b1, 1'b1, 1'b0, 32'd0, 6);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1);
    wait_first_valid("redirect_300", 32'h0000_0300, 40);

    // Randomized traffic
    for (int unsigned i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0,
           $urandom, 1 + ($urandom % 3));
    end
    step(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1);
    wait_first_valid("final_redirect", 32'h0000_0400, 40);

    // Asynchronous reset with the buffer full
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'd0, 1);
    chk("full_before_reset", {31'd0, s_v}, 32'd1);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; id_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 32'd0, 1);
    chk("post_arst_req", {31'd0, s_req}, 32'd1);
    chk("post_arst_addr", s_addr, RST_PC);
    wait_first_valid("post_arst", RST_PC, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
